// File: rtl/player_motion_ctrl.sv
// Per-frame player update: captures the buttons on a frame tick, rotates the heading, and steps the
// position with per-axis wall checks against the map ROM. Outputs change only on the commit cycle.
module player_motion_ctrl #(
    parameter int unsigned MAP_W       = 24,
    parameter int unsigned MAP_H       = 24,
    parameter int unsigned MAP_LATENCY = 2,
    parameter int unsigned ANGLE_STEPS = 64,
    parameter int unsigned INIT_ANGLE  = 32,
    parameter logic [15:0] INIT_POSX   = 16'h1480,
    parameter logic [15:0] INIT_POSY   = 16'h0480,
    parameter logic [15:0] MOVE_STEP   = 16'h0020,
    parameter logic [15:0] FOV_K       = 16'h00A9
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        move_fwd_in,
    input  logic        move_back_in,
    input  logic        rot_left_in,
    input  logic        rot_right_in,
    output logic [9:0]  map_addr_out,
    input  logic [3:0]  map_data_in,
    output logic [15:0] posX,
    output logic [15:0] posY,
    output logic [15:0] dirX,
    output logic [15:0] dirY,
    output logic [15:0] planeX,
    output logic [15:0] planeY,
    output logic        busy_out,
    output logic        valid_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_ROT, S_TRIG, S_VEC, S_CAND, S_CHKX, S_CHKY, S_COMMIT
    } state_t;

    localparam int unsigned AW     = $clog2(ANGLE_STEPS);
    localparam int unsigned ANG_SH = 6 - AW;
    localparam int unsigned WW     = $clog2(MAP_LATENCY + 2);

    state_t          r_state;
    logic [3:0]      r_btn;             // {fwd, back, left, right}
    logic [AW-1:0]   r_angle;
    logic [15:0]     r_cos, r_sin, r_dir_x, r_dir_y, r_plane_x, r_plane_y;
    logic [15:0]     r_cand_x, r_cand_y, r_acc_x;
    logic            r_inx, r_iny, r_iny_ok;
    logic [WW-1:0]   r_wait;

    // Quarter-wave cosine magnitude, round(256*cos(k*pi/32)) for k = 0..16.
    function automatic logic [8:0] quarter(input logic [4:0] k);
        case (k)
            5'd0:    return 9'd256;
            5'd1:    return 9'd255;
            5'd2:    return 9'd251;
            5'd3:    return 9'd245;
            5'd4:    return 9'd237;
            5'd5:    return 9'd226;
            5'd6:    return 9'd213;
            5'd7:    return 9'd198;
            5'd8:    return 9'd181;
            5'd9:    return 9'd162;
            5'd10:   return 9'd142;
            5'd11:   return 9'd121;
            5'd12:   return 9'd98;
            5'd13:   return 9'd74;
            5'd14:   return 9'd50;
            5'd15:   return 9'd25;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [15:0] cos_lut(input logic [5:0] a);
        logic [8:0] mag;
        mag = a[4] ? quarter(5'd16 - 5'(a[3:0])) : quarter(5'(a[3:0]));
        return (a[5] ^ a[4]) ? 16'd0 - {7'd0, mag} : {7'd0, mag};
    endfunction

    function automatic logic [9:0] cell_addr(input logic [7:0] cx, input logic [7:0] cy);
        return 10'(10'(cy) * 10'(MAP_W) + 10'(cx));
    endfunction

    logic [5:0]         w_idx;
    logic signed [31:0] w_sin32, w_cos32, w_dirx32, w_diry32, w_k32, w_ms32;
    logic signed [31:0] w_px_prod, w_py_prod, w_sx_dir, w_sy_dir, w_sx_prod, w_sy_prod;
    logic [15:0]        w_plane_x, w_plane_y, w_step_x, w_step_y, w_acc_x, w_acc_y;
    logic [16:0]        w_sum_x, w_sum_y;
    logic               w_fwd_only, w_back_only, w_inx, w_iny, w_iny_ok, w_map_free, w_wait_done;

    assign w_idx    = 6'(32'(r_angle) << ANG_SH);
    assign w_sin32  = {{16{r_sin[15]}}, r_sin};
    assign w_cos32  = {{16{r_cos[15]}}, r_cos};
    assign w_dirx32 = {{16{r_dir_x[15]}}, r_dir_x};
    assign w_diry32 = {{16{r_dir_y[15]}}, r_dir_y};
    assign w_k32    = {{16{FOV_K[15]}}, FOV_K};
    assign w_ms32   = {{16{MOVE_STEP[15]}}, MOVE_STEP};

    assign w_px_prod = -(w_sin32 * w_k32);
    assign w_py_prod = w_cos32 * w_k32;
    assign w_plane_x = 16'(w_px_prod >>> 8);
    assign w_plane_y = 16'(w_py_prod >>> 8);

    // Opposing move buttons cancel; the sign is applied before the flooring shift.
    assign w_fwd_only  = r_btn[3] & ~r_btn[2];
    assign w_back_only = r_btn[2] & ~r_btn[3];
    assign w_sx_dir    = w_dirx32 * w_ms32;
    assign w_sy_dir    = w_diry32 * w_ms32;
    assign w_sx_prod   = w_fwd_only ? w_sx_dir : (w_back_only ? -w_sx_dir : 32'sd0);
    assign w_sy_prod   = w_fwd_only ? w_sy_dir : (w_back_only ? -w_sy_dir : 32'sd0);
    assign w_step_x    = 16'(w_sx_prod >>> 8);
    assign w_step_y    = 16'(w_sy_prod >>> 8);

    // Bit 16 of the sign-extended sum flags wrap below zero or past 255.99.
    assign w_sum_x = {1'b0, posX} + {w_step_x[15], w_step_x};
    assign w_sum_y = {1'b0, posY} + {w_step_y[15], w_step_y};
    assign w_inx   = ~w_sum_x[16] && ({1'b0, w_sum_x[15:8]} < 9'(MAP_W));
    assign w_iny   = ~w_sum_y[16] && ({1'b0, w_sum_y[15:8]} < 9'(MAP_H));

    assign w_map_free  = (map_data_in == 4'd0);
    assign w_wait_done = (r_wait == WW'(MAP_LATENCY));
    assign w_acc_x     = (r_inx && w_map_free) ? r_cand_x : posX;
    assign w_iny_ok    = r_iny && ({1'b0, w_acc_x[15:8]} < 9'(MAP_W));
    assign w_acc_y     = (r_iny_ok && w_map_free) ? r_cand_y : posY;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_btn        <= 4'd0;
            r_angle      <= AW'(INIT_ANGLE);
            r_cos        <= 16'hFF00;
            r_sin        <= 16'h0000;
            r_dir_x      <= 16'hFF00;
            r_dir_y      <= 16'h0000;
            r_plane_x    <= 16'h0000;
            r_plane_y    <= 16'hFF57;
            r_cand_x     <= 16'h0000;
            r_cand_y     <= 16'h0000;
            r_acc_x      <= 16'h0000;
            r_inx        <= 1'b0;
            r_iny        <= 1'b0;
            r_iny_ok     <= 1'b0;
            r_wait       <= '0;
            map_addr_out <= 10'd0;
            posX         <= INIT_POSX;
            posY         <= INIT_POSY;
            dirX         <= 16'hFF00;
            dirY         <= 16'h0000;
            planeX       <= 16'h0000;
            planeY       <= 16'hFF57;
            busy_out     <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_tick_in) begin
                        r_btn    <= {move_fwd_in, move_back_in, rot_left_in, rot_right_in};
                        busy_out <= 1'b1;
                        r_state  <= S_ROT;
                    end
                end
                S_ROT: begin
                    if (r_btn[1] && !r_btn[0]) begin
                        r_angle <= r_angle + AW'(1);
                    end else if (r_btn[0] && !r_btn[1]) begin
                        r_angle <= r_angle - AW'(1);
                    end
                    r_state <= S_TRIG;
                end
                S_TRIG: begin
                    r_cos   <= cos_lut(w_idx);
                    r_sin   <= cos_lut(w_idx - 6'd16);
                    r_state <= S_VEC;
                end
                S_VEC: begin
                    r_dir_x   <= r_cos;
                    r_dir_y   <= r_sin;
                    r_plane_x <= w_plane_x;
                    r_plane_y <= w_plane_y;
                    r_state   <= S_CAND;
                end
                S_CAND: begin
                    r_cand_x     <= w_sum_x[15:0];
                    r_cand_y     <= w_sum_y[15:0];
                    r_inx        <= w_inx;
                    r_iny        <= w_iny;
                    map_addr_out <= w_inx ? cell_addr(w_sum_x[15:8], posY[15:8]) : 10'd0;
                    r_wait       <= '0;
                    r_state      <= S_CHKX;
                end
                S_CHKX: begin
                    if (w_wait_done) begin
                        r_acc_x      <= w_acc_x;
                        r_iny_ok     <= w_iny_ok;
                        map_addr_out <= w_iny_ok ? cell_addr(w_acc_x[15:8], r_cand_y[15:8]) : 10'd0;
                        r_wait       <= '0;
                        r_state      <= S_CHKY;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_CHKY: begin
                    if (w_wait_done) begin
                        posX      <= r_acc_x;
                        posY      <= w_acc_y;
                        dirX      <= r_dir_x;
                        dirY      <= r_dir_y;
                        planeX    <= r_plane_x;
                        planeY    <= r_plane_y;
                        valid_out <= 1'b1;
                        r_state   <= S_COMMIT;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_COMMIT: begin
                    busy_out <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with a two-stage pipelined map ROM model.
module tb_player_motion_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        move_fwd = 1'b0, move_back = 1'b0, rot_left = 1'b0, rot_right = 1'b0;
    logic [9:0]  map_addr_out;
    logic [3:0]  map_data;
    logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
    logic        busy_out, valid_out;

    int checks = 0;
    int failures = 0;
    int lat;
    int nvalid;
    int first_valid;

    logic [3:0] map_mem [0:575];
    logic [3:0] map_d1, map_d2;

    player_motion_ctrl dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .frame_tick_in (frame_tick),
        .move_fwd_in   (move_fwd),
        .move_back_in  (move_back),
        .rot_left_in   (rot_left),
        .rot_right_in  (rot_right),
        .map_addr_out  (map_addr_out),
        .map_data_in   (map_data),
        .posX          (posX),
        .posY          (posY),
        .dirX          (dirX),
        .dirY          (dirY),
        .planeX        (planeX),
        .planeY        (planeY),
        .busy_out      (busy_out),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    // Data is valid two cycles after the address appears.
    always @(posedge clk) begin
        map_d1 <= (map_addr_out < 10'd576) ? map_mem[map_addr_out] : 4'd0;
        map_d2 <= map_d1;
    end
    assign map_data = map_d2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check6(input string tag, input logic [15:0] px, input logic [15:0] py,
                          input logic [15:0] dx, input logic [15:0] dy,
                          input logic [15:0] plx, input logic [15:0] ply);
        check({tag, "_posX"}, posX, px);
        check({tag, "_posY"}, posY, py);
        check({tag, "_dirX"}, dirX, dx);
        check({tag, "_dirY"}, dirY, dy);
        check({tag, "_planeX"}, planeX, plx);
        check({tag, "_planeY"}, planeY, ply);
    endtask

    // Buttons are {fwd, back, left, right}; released right after the capturing edge.
    task automatic do_tick(input logic [3:0] btn, output int l);
        {move_fwd, move_back, rot_left, rot_right} = btn;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        {move_fwd, move_back, rot_left, rot_right} = 4'b0000;
        l = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic tick_idle(input string tag, input logic [3:0] btn);
        int l;
        do_tick(btn, l);
        check(tag, l, 10);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 576; i++) map_mem[i] = 4'd0;

        // Reset state, both while held and after release
        repeat (3) @(posedge clk);
        #1;
        check6("rst_held", 16'h1480, 16'h0480, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_addr", map_addr_out, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check6("rst_rel", 16'h1480, 16'h0480, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);

        // Forward one step on an empty map; latency and busy window
        do_tick(4'b1000, lat);
        check("fwd_lat", lat, 10);
        check6("fwd1", 16'h1460, 16'h0480, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);
        check("commit_busy", busy_out, 1);
        @(posedge clk); #1;
        check("after_commit_busy", busy_out, 0);
        check("after_commit_valid", valid_out, 0);

        // Heading 43 exercises floor rounding of negative steps on both axes
        for (int n = 0; n < 11; n++) tick_idle("rotL_lat", 4'b0010);
        do_tick(4'b1000, lat);
        check("a43_lat", lat, 10);
        check6("a43_fwd", 16'h1450, 16'h0463, 16'hFF87, 16'hFF1E, 16'h0095, 16'hFFB0);
        @(posedge clk); #1;

        for (int n = 0; n < 11; n++) tick_idle("rotR_lat", 4'b0001);
        check6("back_a32", 16'h1450, 16'h0463, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);
        tick_idle("fwd_lat", 4'b1000);
        tick_idle("fwd_lat", 4'b1000);
        check("pos_1410", posX, 16'h1410);

        // Wall at cell (19,4) blocks X; clearing it lets the move through
        map_mem[4*24+19] = 4'd1;
        do_tick(4'b1000, lat);
        check("wall_lat", lat, 10);
        check("wall_posX", posX, 16'h1410);
        check("wall_posY", posY, 16'h0463);
        @(posedge clk); #1;
        map_mem[4*24+19] = 4'd0;
        do_tick(4'b1000, lat);
        check("clear_lat", lat, 10);
        check("clear_posX", posX, 16'h13F0);

        // Tick during the commit cycle is dropped
        move_fwd = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        move_fwd = 1'b0;
        nvalid = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (valid_out) nvalid++;
        end
        check("commit_tick_ignored", nvalid, 0);
        check("commit_tick_posX", posX, 16'h13F0);

        // Rotate left from 32; then a tick on the cycle right after commit is taken
        do_tick(4'b0010, lat);
        check("a33_lat", lat, 10);
        check6("a33", 16'h13F0, 16'h0463, 16'hFF01, 16'hFFE7, 16'h0010, 16'hFF57);
        @(posedge clk); #1;
        check("a33_idle_busy", busy_out, 0);
        do_tick(4'b0010, lat);
        check("post_commit_lat", lat, 10);
        check6("a34", 16'h13F0, 16'h0463, 16'hFF05, 16'hFFCE, 16'h0021, 16'hFF5A);
        @(posedge clk); #1;

        // Walk to 63 then wrap to 0
        for (int n = 0; n < 29; n++) tick_idle("rotL_lat", 4'b0010);
        check6("a63", 16'h13F0, 16'h0463, 16'h00FF, 16'hFFE7, 16'h0010, 16'h00A8);
        do_tick(4'b0010, lat);
        check("wrap_lat", lat, 10);
        check6("a0", 16'h13F0, 16'h0463, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        @(posedge clk); #1;

        // All buttons cancel; a second tick mid-update is ignored
        {move_fwd, move_back, rot_left, rot_right} = 4'b1111;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        nvalid = 0;
        first_valid = -1;
        for (int i = 1; i <= 30; i++) begin
            {move_fwd, move_back, rot_left, rot_right} = 4'b0000;
            frame_tick = (i == 3);
            move_fwd = (i == 3);
            @(posedge clk); #1;
            if (valid_out) begin
                nvalid++;
                if (first_valid < 0) first_valid = i;
            end
        end
        frame_tick = 1'b0;
        move_fwd = 1'b0;
        check("cancel_npulses", nvalid, 1);
        check("cancel_lat", first_valid, 10);
        check6("cancel", 16'h13F0, 16'h0463, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);

        // Reset mid-update: immediate reset values, no commit afterwards
        move_fwd = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        move_fwd = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check6("midrst", 16'h1480, 16'h0480, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);
        check("midrst_valid", valid_out, 0);
        check("midrst_busy", busy_out, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (valid_out) nvalid++;
        end
        check("midrst_no_valid", nvalid, 0);
        check("midrst_posX", posX, 16'h1480);

        // Heading also returned to 32
        do_tick(4'b1000, lat);
        check("postrst_lat", lat, 10);
        check6("postrst", 16'h1460, 16'h0480, 16'hFF00, 16'h0000, 16'h0000, 16'hFF57);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
